// File: rtl/imm_pkg.sv
// Shared types, opcode constants and decode helpers for the pipelined immediate generator.
package imm_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned FMT_W   = 3;
   localparam int unsigned IMM64_W = 64;

   typedef enum logic [FMT_W-1:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_Z   = 3'd6,
      FMT_ILL = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // CSR-immediate forms (funct3[2]=1) carry a 5-bit zimm in rs1; other SYSTEM forms have none.
   function automatic fmt_e imm_fmt(input logic [INSTR_W-1:0] instr);
      fmt_e f;
      case (instr[6:0])
         OP_LUI, OP_AUIPC:                      f = FMT_U;
         OP_JAL:                                f = FMT_J;
         OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE:  f = FMT_I;
         OP_STORE:                              f = FMT_S;
         OP_BRANCH:                             f = FMT_B;
         OP_OP:                                 f = FMT_R;
         OP_SYSTEM:                             f = instr[14] ? FMT_Z : FMT_R;
         default:                               f = FMT_ILL;
      endcase
      return f;
   endfunction

   function automatic logic [IMM64_W-1:0] imm_build(input logic [INSTR_W-1:0] instr,
                                                    input fmt_e f);
      logic [IMM64_W-1:0] imm;
      case (f)
         FMT_I:   imm = {{52{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
         FMT_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_Z:   imm = {59'b0, instr[19:15]};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out valid-ready channel pair plus the redirect flush.
interface imm_gen_pipe_if
   import imm_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
);
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_imm;
   fmt_e               out_fmt;
   logic               out_illegal;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output flush, in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
   );

   modport slave (
      input  flush, in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
   );
endinterface

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready skid buffer: main register drives the outputs, skid absorbs one beat
// accepted while main is stalled. in_ready comes straight from the skid valid flop.
module imm_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         main_valid, main_valid_n;
   logic         skid_valid, skid_valid_n;
   logic [W-1:0] main_data;
   logic [W-1:0] skid_data;
   logic         in_xfer, out_xfer;
   logic         main_load, main_from_skid, skid_load;

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;

   // Flush wins over everything; skid refills main first so order stays FIFO.
   always_comb begin
      main_valid_n   = main_valid;
      skid_valid_n   = skid_valid;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      in_xfer        = in_valid & ~skid_valid;
      out_xfer       = main_valid & out_ready;
      if (flush) begin
         main_valid_n = 1'b0;
         skid_valid_n = 1'b0;
      end else if (out_xfer) begin
         if (skid_valid) begin
            main_from_skid = 1'b1;
            skid_valid_n   = 1'b0;
         end else if (in_xfer) begin
            main_load = 1'b1;
         end else begin
            main_valid_n = 1'b0;
         end
      end else if (in_xfer) begin
         if (main_valid) begin
            skid_load    = 1'b1;
            skid_valid_n = 1'b1;
         end else begin
            main_load    = 1'b1;
            main_valid_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
      end else begin
         main_valid <= main_valid_n;
         skid_valid <= skid_valid_n;
         if (main_from_skid)
            main_data <= skid_data;
         else if (main_load)
            main_data <= in_data;
      end
   end

   // Skid payload never reaches the outputs directly, so it carries no reset.
   always_ff @(posedge clk) begin
      if (skid_load)
         skid_data <= in_data;
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational format/immediate decode feeding a
// registered two-entry skid buffer with synchronous flush.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input logic          clk,
   input logic          rst,
   imm_gen_pipe_if.slave bus
);
   localparam int unsigned PAY_W = TAG_W + 1 + FMT_W + XLEN;

   fmt_e             fmt_c;
   logic [XLEN-1:0]  imm_c;
   logic [PAY_W-1:0] pay_in, pay_out;

   assign fmt_c  = imm_fmt(bus.in_instr);
   assign imm_c  = XLEN'(imm_build(bus.in_instr, fmt_c));
   assign pay_in = {bus.in_tag, (fmt_c == FMT_ILL), fmt_c, imm_c};

   imm_skid_buf #(.W(PAY_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (pay_in),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (pay_out)
   );

   assign bus.out_imm     = pay_out[XLEN-1:0];
   assign bus.out_fmt     = fmt_e'(pay_out[XLEN +: FMT_W]);
   assign bus.out_illegal = pay_out[XLEN + FMT_W];
   assign bus.out_tag     = pay_out[XLEN + FMT_W + 1 +: TAG_W];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors, back-pressure, flush and async reset.
module tb_imm_gen_pipe;
   import imm_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errs   = 0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [31:0] instr, input logic [31:0] tag);
      b32.in_valid = v;
      b32.in_instr = instr;
      b32.in_tag   = tag;
   endtask

   // addi x1, x0, k : I-type whose immediate equals k
   function automatic logic [31:0] addi(input logic [31:0] k);
      return {k[11:0], 20'h00093};
   endfunction

   task automatic chk_out(input string tag, input logic [31:0] etag, input logic [31:0] eimm);
      chk({tag, ".valid"}, 64'(b32.out_valid), 64'd1);
      chk({tag, ".tag"},   64'(b32.out_tag),   64'(etag));
      chk({tag, ".imm"},   64'(b32.out_imm),   64'(eimm));
   endtask

   logic [31:0] vin  [6] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3,
                             32'hFF9FF06F, 32'h123452B7, 32'h1F0FD073};
   logic [31:0] vimm [6] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC,
                             32'hFFFFFFF8, 32'h12345000, 32'h0000001F};
   logic [2:0]  vfmt [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6};

   initial begin
      rst = 1'b1;
      b32.flush = 1'b0; b32.out_ready = 1'b1; put(1'b0, 32'h0, 32'h0);
      b64.flush = 1'b0; b64.out_ready = 1'b1;
      b64.in_valid = 1'b0; b64.in_instr = 32'h0; b64.in_tag = 32'h0;
      #12;
      chk("rst.out_valid",   64'(b32.out_valid),   64'd0);
      chk("rst.in_ready",    64'(b32.in_ready),    64'd1);
      chk("rst.out_imm",     64'(b32.out_imm),     64'd0);
      chk("rst.out_fmt",     64'(b32.out_fmt),     64'd0);
      chk("rst.out_illegal", 64'(b32.out_illegal), 64'd0);
      chk("rst.out_tag",     64'(b32.out_tag),     64'd0);
      rst = 1'b0;

      // Back-to-back decode vectors, one per cycle with 1-cycle latency
      for (int i = 0; i < 6; i++) begin
         put(1'b1, vin[i], 32'(i + 1));
         tick();
         chk_out($sformatf("b2b%0d", i), 32'(i + 1), vimm[i]);
         chk($sformatf("b2b%0d.fmt", i), 64'(b32.out_fmt), 64'(vfmt[i]));
         chk($sformatf("b2b%0d.ill", i), 64'(b32.out_illegal), 64'd0);
      end
      put(1'b0, 32'h0, 32'h0);
      tick();
      chk("b2b.drain", 64'(b32.out_valid), 64'd0);

      // Illegal opcode and R-type
      put(1'b1, 32'h0000007F, 32'h77);
      tick();
      chk_out("ill", 32'h77, 32'h0);
      chk("ill.fmt", 64'(b32.out_fmt),     64'd7);
      chk("ill.ill", 64'(b32.out_illegal), 64'd1);
      put(1'b1, 32'h002081B3, 32'h78);
      tick();
      chk_out("add", 32'h78, 32'h0);
      chk("add.fmt", 64'(b32.out_fmt),     64'd0);
      chk("add.ill", 64'(b32.out_illegal), 64'd0);
      put(1'b0, 32'h0, 32'h0);
      tick();

      // Back-pressure: two accepts then in_ready drops; FIFO drain in order
      b32.out_ready = 1'b0;
      put(1'b1, addi(100), 100);
      tick();
      chk_out("bp0", 100, 100);
      chk("bp0.in_ready", 64'(b32.in_ready), 64'd1);
      put(1'b1, addi(101), 101);
      tick();
      chk_out("bp1", 100, 100);
      chk("bp1.in_ready", 64'(b32.in_ready), 64'd0);
      put(1'b1, addi(102), 102);
      tick();
      chk_out("bp2", 100, 100);
      chk("bp2.in_ready", 64'(b32.in_ready), 64'd0);
      b32.out_ready = 1'b1;
      tick();
      chk_out("bp3", 101, 101);
      chk("bp3.in_ready", 64'(b32.in_ready), 64'd1);
      tick();
      chk_out("bp4", 102, 102);
      put(1'b1, addi(103), 103);
      tick();
      chk_out("bp5", 103, 103);
      put(1'b0, 32'h0, 32'h0);
      tick();
      chk("bp.drain", 64'(b32.out_valid), 64'd0);

      // Flush with main and skid full plus a pending input
      b32.out_ready = 1'b0;
      put(1'b1, addi(200), 200);
      tick();
      put(1'b1, addi(201), 201);
      tick();
      chk("fl.full", 64'(b32.in_ready), 64'd0);
      put(1'b1, addi(202), 202);
      b32.flush = 1'b1;
      tick();
      b32.flush = 1'b0;
      chk("fl.out_valid", 64'(b32.out_valid), 64'd0);
      chk("fl.in_ready",  64'(b32.in_ready),  64'd1);
      put(1'b0, 32'h0, 32'h0);
      tick();
      chk("fl.gone", 64'(b32.out_valid), 64'd0);

      // Flush beats an input that would otherwise transfer
      put(1'b1, addi(210), 210);
      tick();
      put(1'b1, addi(211), 211);
      b32.flush = 1'b1;
      tick();
      b32.flush = 1'b0;
      put(1'b0, 32'h0, 32'h0);
      chk("fl2.out_valid", 64'(b32.out_valid), 64'd0);
      chk("fl2.in_ready",  64'(b32.in_ready),  64'd1);
      b32.out_ready = 1'b1;
      put(1'b1, addi(203), 203);
      tick();
      chk_out("fl.resume", 203, 203);
      put(1'b0, 32'h0, 32'h0);
      tick();
      chk("fl.resume.drain", 64'(b32.out_valid), 64'd0);

      // Async reset mid-stream with both entries occupied
      b32.out_ready = 1'b0;
      put(1'b1, 32'hFE000EE3, 300);
      tick();
      put(1'b1, addi(301), 301);
      tick();
      put(1'b0, 32'h0, 32'h0);
      #2 rst = 1'b1;
      #1;
      chk("arst.out_valid",   64'(b32.out_valid),   64'd0);
      chk("arst.in_ready",    64'(b32.in_ready),    64'd1);
      chk("arst.out_imm",     64'(b32.out_imm),     64'd0);
      chk("arst.out_fmt",     64'(b32.out_fmt),     64'd0);
      chk("arst.out_illegal", 64'(b32.out_illegal), 64'd0);
      chk("arst.out_tag",     64'(b32.out_tag),     64'd0);
      #1 rst = 1'b0;
      b32.out_ready = 1'b1;
      put(1'b1, addi(302), 302);
      tick();
      chk_out("arst.resume", 302, 302);
      put(1'b0, 32'h0, 32'h0);
      tick();
      chk("arst.drain", 64'(b32.out_valid), 64'd0);

      // XLEN=64 sign extension of I and U immediates
      b64.in_valid = 1'b1; b64.in_instr = 32'hFFF00093; b64.in_tag = 32'h64;
      tick();
      chk("x64.i.valid", 64'(b64.out_valid), 64'd1);
      chk("x64.i.imm",   b64.out_imm,        64'hFFFFFFFFFFFFFFFF);
      b64.in_instr = 32'h800002B7; b64.in_tag = 32'h65;
      tick();
      chk("x64.u.imm",   b64.out_imm,        64'hFFFFFFFF80000000);
      chk("x64.u.fmt",   64'(b64.out_fmt),   64'd4);
      chk("x64.u.tag",   64'(b64.out_tag),   64'h65);
      b64.in_valid = 1'b0;
      tick();
      chk("x64.drain",   64'(b64.out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
      $finish;
   end

endmodule
